// File: rtl/game_flow_ctrl.sv
// Match sequencer: serve, play, miss and game-over, paced by the display frame tick.
// Optional pause feature compiled in with `define PAUSE_GAME_EN.
module game_flow_ctrl #(
    parameter int unsigned LIVES          = 3,
    parameter int unsigned SERVE_FRAMES   = 60,
    parameter int unsigned MISS_FRAMES    = 90,
    parameter int unsigned HITS_PER_LEVEL = 5
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        frame_tick,
    input  logic        hit,
    input  logic        lose,
    output logic        play_en,
    output logic        ball_reset,
    output logic [2:0]  speed_level,
    output logic [1:0]  lives,
    output logic [13:0] score,
    output logic        game_over
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SERVE  = 3'd1;
    localparam logic [2:0] PLAY   = 3'd2;
    localparam logic [2:0] MISS   = 3'd3;
    localparam logic [2:0] OVER   = 3'd4;
`ifdef PAUSE_GAME_EN
    localparam logic [2:0] PAUSED = 3'd5;
`endif
    localparam int unsigned SCORE_MAX = 9999;
    localparam int unsigned SPEED_MAX = 7;

    logic [2:0]  state, state_nx;
    logic [7:0]  frame_cnt, frame_nx;
    logic [7:0]  hit_cnt, hit_nx;
    logic [13:0] score_nx;
    logic [1:0]  lives_nx;
    logic [2:0]  speed_nx;
    logic        state_entry;
    logic        start_q, lose_q;
    logic        start_rise, lose_rise;

    assign start_rise = start & ~start_q;
    assign lose_rise  = lose & ~lose_q;

`ifdef PAUSE_GAME_EN
    logic pause_q;
    logic pause_rise;
    assign pause_rise = pause & ~pause_q;

    always_ff @(posedge mclk) begin
        if (rst) pause_q <= 1'b0;
        else     pause_q <= pause;
    end
`else
    logic pause_unused;
    assign pause_unused = pause;
`endif

    // Next-state and next-counter logic; ticks in a state's entry cycle are not counted
    always_comb begin
        state_nx = state;
        frame_nx = frame_cnt;
        hit_nx   = hit_cnt;
        score_nx = score;
        lives_nx = lives;
        speed_nx = speed_level;
        case (state)
            IDLE, OVER: begin
                if (start_rise) begin
                    state_nx = SERVE;
                    frame_nx = 8'd0;
                    hit_nx   = 8'd0;
                    score_nx = 14'd0;
                    lives_nx = 2'(LIVES);
                    speed_nx = 3'd0;
                end
            end
            SERVE: begin
                if (frame_tick && !state_entry) begin
                    if (frame_cnt == 8'(SERVE_FRAMES - 1)) state_nx = PLAY;
                    else                                   frame_nx = frame_cnt + 8'd1;
                end
            end
            PLAY: begin
                if (lose_rise) begin
                    state_nx = MISS;
                    frame_nx = 8'd0;
                    if (lives != 2'd0) lives_nx = lives - 2'd1;
                end else begin
                    if (hit) begin
                        if (score != 14'(SCORE_MAX)) score_nx = score + 14'd1;
                        if (hit_cnt + 8'd1 == 8'(HITS_PER_LEVEL)) begin
                            hit_nx = 8'd0;
                            if (speed_level != 3'(SPEED_MAX)) speed_nx = speed_level + 3'd1;
                        end else begin
                            hit_nx = hit_cnt + 8'd1;
                        end
                    end
`ifdef PAUSE_GAME_EN
                    if (pause_rise) state_nx = PAUSED;
`endif
                end
            end
            MISS: begin
                if (frame_tick && !state_entry) begin
                    if (frame_cnt == 8'(MISS_FRAMES - 1)) begin
                        state_nx = (lives == 2'd0) ? OVER : SERVE;
                        frame_nx = 8'd0;
                    end else begin
                        frame_nx = frame_cnt + 8'd1;
                    end
                end
            end
`ifdef PAUSE_GAME_EN
            PAUSED: begin
                if (pause_rise) state_nx = PLAY;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    // State, counters and registered outputs derived from the next state
    always_ff @(posedge mclk) begin
        if (rst) begin
            state       <= IDLE;
            frame_cnt   <= 8'd0;
            hit_cnt     <= 8'd0;
            score       <= 14'd0;
            lives       <= 2'd0;
            speed_level <= 3'd0;
            state_entry <= 1'b0;
            start_q     <= 1'b0;
            lose_q      <= 1'b0;
            play_en     <= 1'b0;
            ball_reset  <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_nx;
            frame_cnt   <= frame_nx;
            hit_cnt     <= hit_nx;
            score       <= score_nx;
            lives       <= lives_nx;
            speed_level <= speed_nx;
            state_entry <= (state_nx != state);
            start_q     <= start;
            lose_q      <= lose;
            play_en     <= (state_nx == PLAY);
            ball_reset  <= (state_nx == SERVE) && (state != SERVE);
            game_over   <= (state_nx == OVER);
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with default parameters; pause checks follow PAUSE_GAME_EN.
module tb_game_flow_ctrl;

    logic        mclk = 1'b0;
    logic        rst, start, pause, frame_tick, hit, lose;
    logic        play_en, ball_reset, game_over;
    logic [2:0]  speed_level;
    logic [1:0]  lives;
    logic [13:0] score;

    int errors = 0;
    int checks = 0;

    game_flow_ctrl dut (
        .mclk        (mclk),
        .rst         (rst),
        .start       (start),
        .pause       (pause),
        .frame_tick  (frame_tick),
        .hit         (hit),
        .lose        (lose),
        .play_en     (play_en),
        .ball_reset  (ball_reset),
        .speed_level (speed_level),
        .lives       (lives),
        .score       (score),
        .game_over   (game_over)
    );

    always #5 mclk = ~mclk;

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic hits(input int n);
        hit = 1'b1;
        repeat (n) step();
        hit = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_play_en"}, 32'(play_en), 0);
        chk({tag, "_ball_reset"}, 32'(ball_reset), 0);
        chk({tag, "_speed"}, 32'(speed_level), 0);
        chk({tag, "_lives"}, 32'(lives), 0);
        chk({tag, "_score"}, 32'(score), 0);
        chk({tag, "_game_over"}, 32'(game_over), 0);
        chk({tag, "_state"}, 32'(dut.state), 0);
    endtask

    // Called one cycle after SERVE entry; play_en must rise exactly at the 60th tick edge
    task automatic serve_to_play();
        ticks(59);
        chk("serve_hold_play_en", 32'(play_en), 0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("serve_done_play_en", 32'(play_en), 1);
    endtask

    // Lose rise (optionally with a coincident hit), a tick in the MISS entry cycle, then 90 ticks
    task automatic lose_ball(input logic with_hit, input logic [1:0] exp_lives,
                             input logic [13:0] exp_score);
        hit  = with_hit;
        lose = 1'b1;
        step();
        hit  = 1'b0;
        lose = 1'b0;
        chk("miss_play_en", 32'(play_en), 0);
        chk("miss_lives", 32'(lives), 32'(exp_lives));
        chk("miss_score", 32'(score), 32'(exp_score));
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        ticks(89);
        chk("miss_hold_ball_reset", 32'(ball_reset), 0);
        chk("miss_hold_game_over", 32'(game_over), 0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        if (exp_lives != 2'd0) begin
            chk("reserve_ball_reset", 32'(ball_reset), 1);
            chk("reserve_game_over", 32'(game_over), 0);
            step();
            chk("reserve_pulse_len", 32'(ball_reset), 0);
        end else begin
            chk("over_game_over", 32'(game_over), 1);
            chk("over_ball_reset", 32'(ball_reset), 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; frame_tick = 1'b0; hit = 1'b0; lose = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_reset_outputs("reset");

        // First game: start rise enters SERVE with a one-cycle ball_reset
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ball_reset", 32'(ball_reset), 1);
        chk("start_lives", 32'(lives), 3);
        chk("start_score", 32'(score), 0);
        chk("start_play_en", 32'(play_en), 0);
        step();
        chk("serve_pulse_len", 32'(ball_reset), 0);
        serve_to_play();

        hits(12);
        chk("hits12_score", 32'(score), 12);
        chk("hits12_speed", 32'(speed_level), 2);

        // Coincident hit and lose rise: lose wins
        lose_ball(1'b1, 2'd2, 14'd12);
        serve_to_play();
        chk("life2_speed_kept", 32'(speed_level), 2);

        hits(9990);
        chk("sat_score", 32'(score), 9999);
        chk("sat_speed", 32'(speed_level), 7);

        lose_ball(1'b0, 2'd1, 14'd9999);
        serve_to_play();
        lose_ball(1'b0, 2'd0, 14'd9999);
        chk("over_score_held", 32'(score), 9999);
        chk("over_speed_held", 32'(speed_level), 7);
        chk("over_lives", 32'(lives), 0);
        chk("over_play_en", 32'(play_en), 0);
        hits(3);
        chk("over_hit_ignored", 32'(score), 9999);

        // Restart from OVER
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_lives", 32'(lives), 3);
        chk("restart_score", 32'(score), 0);
        chk("restart_speed", 32'(speed_level), 0);
        chk("restart_game_over", 32'(game_over), 0);
        chk("restart_ball_reset", 32'(ball_reset), 1);
        step();

        // Reset mid-SERVE, then frame ticks must do nothing
        ticks(10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("rst_serve");
        ticks(70);
        chk_reset_outputs("rst_serve_idle");

        // Reset mid-MISS count
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        serve_to_play();
        lose = 1'b1;
        step();
        lose = 1'b0;
        chk("miss2_lives", 32'(lives), 2);
        ticks(30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("rst_miss");
        ticks(100);
        chk_reset_outputs("rst_miss_idle");

        // Pause behaviour
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        serve_to_play();
        pause = 1'b1;
        step();
        pause = 1'b0;
`ifdef PAUSE_GAME_EN
        chk("pause_play_en", 32'(play_en), 0);
        hits(3);
        chk("pause_score_frozen", 32'(score), 0);
        lose = 1'b1;
        step();
        chk("pause_lose_ignored", 32'(lives), 3);
        pause = 1'b1;
        step();
        pause = 1'b0;
        chk("resume_play_en", 32'(play_en), 1);
        step();
        chk("resume_no_lose", 32'(lives), 3);
        lose = 1'b0;
        hits(1);
        chk("resume_score", 32'(score), 1);
`else
        chk("nopause_play_en", 32'(play_en), 1);
        hits(3);
        chk("nopause_score", 32'(score), 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
